// File: rtl/seg_capture.sv
// Recovers the digits of a multiplexed active-low 7-segment display into a 16-bit hex value.
// Latency is 3+STABLE_CYC clkin edges from an input change to capture; input only, no backpressure.
module seg_capture #(
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic        clkin,
  input  logic        reset,
  input  logic [3:0]  Anode,
  input  logic [6:0]  Cathode,
  output logic [15:0] data_out,
  output logic [3:0]  digit_valid,
  output logic [15:0] frame_out,
  output logic        frame_valid,
  output logic        seg_err,
  output logic        anode_err
);

  localparam logic [7:0] CNT_SAT = 8'(STABLE_CYC);
  localparam logic [7:0] CNT_CAP = 8'(STABLE_CYC - 1);

  // Active-high gfedcba glyph to {hit, nibble}.
  function automatic logic [4:0] glyph_decode(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h3F:   r = {1'b1, 4'h0};
      7'h06:   r = {1'b1, 4'h1};
      7'h5B:   r = {1'b1, 4'h2};
      7'h4F:   r = {1'b1, 4'h3};
      7'h66:   r = {1'b1, 4'h4};
      7'h6D:   r = {1'b1, 4'h5};
      7'h7D:   r = {1'b1, 4'h6};
      7'h07:   r = {1'b1, 4'h7};
      7'h7F:   r = {1'b1, 4'h8};
      7'h6F:   r = {1'b1, 4'h9};
      7'h77:   r = {1'b1, 4'hA};
      7'h7C:   r = {1'b1, 4'hB};
      7'h39:   r = {1'b1, 4'hC};
      7'h5E:   r = {1'b1, 4'hD};
      7'h79:   r = {1'b1, 4'hE};
      7'h71:   r = {1'b1, 4'hF};
      default: r = {1'b0, 4'h0};
    endcase
    return r;
  endfunction

  logic [10:0] s1_q, s2_q, prev_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] data_q, data_d;
  logic [3:0]  dv_q, dv_d;
  logic [15:0] frame_q, frame_d;
  logic        fv_q, fv_d;
  logic        seg_err_q, seg_err_d;
  logic        anode_err_q, anode_err_d;

  logic        eq;
  logic        capture;
  logic [3:0]  anode_s;
  logic [6:0]  cath_s;
  logic [3:0]  sel_mask;
  logic [2:0]  low_cnt;
  logic [4:0]  dec;
  logic [3:0]  dv_next;

  assign anode_s  = s2_q[10:7];
  assign cath_s   = s2_q[6:0];
  assign sel_mask = ~anode_s;
  assign eq       = (s2_q == prev_q);
  assign capture  = eq && (cnt_q == CNT_CAP);
  assign dec      = glyph_decode(~cath_s);

  always_comb begin
    low_cnt = 3'd0;
    for (int i = 0; i < 4; i++) begin
      low_cnt = low_cnt + {2'b00, sel_mask[i]};
    end
  end

  always_comb begin
    if (!eq) begin
      cnt_d = 8'd0;
    end else if (cnt_q < CNT_SAT) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_comb begin
    data_d      = data_q;
    dv_d        = dv_q;
    dv_next     = dv_q;
    frame_d     = frame_q;
    fv_d        = 1'b0;
    seg_err_d   = seg_err_q;
    anode_err_d = anode_err_q;
    if (capture) begin
      if (anode_s == 4'hF) begin
        // Blanking interval between digits: nothing to record.
        dv_d = dv_q;
      end else if (low_cnt >= 3'd2) begin
        anode_err_d = 1'b1;
      end else if (dec[4]) begin
        for (int i = 0; i < 4; i++) begin
          if (sel_mask[i]) begin
            data_d[4*i +: 4] = dec[3:0];
          end
        end
        dv_next = dv_q | sel_mask;
        if (dv_next == 4'hF) begin
          frame_d = data_d;
          fv_d    = 1'b1;
          dv_d    = 4'h0;
        end else begin
          dv_d = dv_next;
        end
      end else begin
        seg_err_d = 1'b1;
        dv_d      = dv_q & ~sel_mask;
      end
    end
  end

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      s1_q        <= '1;
      s2_q        <= '1;
      prev_q      <= '1;
      cnt_q       <= 8'd0;
      data_q      <= 16'h0000;
      dv_q        <= 4'h0;
      frame_q     <= 16'h0000;
      fv_q        <= 1'b0;
      seg_err_q   <= 1'b0;
      anode_err_q <= 1'b0;
    end else begin
      s1_q        <= {Anode, Cathode};
      s2_q        <= s1_q;
      prev_q      <= s2_q;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      dv_q        <= dv_d;
      frame_q     <= frame_d;
      fv_q        <= fv_d;
      seg_err_q   <= seg_err_d;
      anode_err_q <= anode_err_d;
    end
  end

  assign data_out    = data_q;
  assign digit_valid = dv_q;
  assign frame_out   = frame_q;
  assign frame_valid = fv_q;
  assign seg_err     = seg_err_q;
  assign anode_err   = anode_err_q;

endmodule

// File: doc/seg_capture.md
SEG_CAPTURE -- requirements
Module: seg_capture

Interface
REQ-001 Parameter STABLE_CYC, default 4: consecutive equal synchronized samples required before a digit is captured; legal range 2..255.
REQ-002 clkin  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; reset=0 forces reset state immediately, release is synchronous to clkin.
REQ-004 Anode  input  4  multiplexed digit select, active-low one-hot; Anode[0]=0 selects digit 0 (least significant).
REQ-005 Cathode  input  7  segment lines, active-low; Cathode[0]=a … Cathode[6]=g.
REQ-006 data_out  output  16  working nibble store; digit n at data_out[4n+3:4n].
REQ-007 digit_valid  output  4  bit n set when digit n captured since last frame.
REQ-008 frame_out  output  16  last complete four-digit value.
REQ-009 frame_valid  output  1  one-cycle pulse when frame_out updates.
REQ-010 seg_err  output  1  sticky: stable cathode pattern not a legal hex glyph.
REQ-011 anode_err  output  1  sticky: stable Anode with more than one bit low.

Function
REQ-012 Anode and Cathode SHALL pass through a 2-flop synchronizer (s1, s2) before any use.
REQ-013 A register prev SHALL hold s2 delayed one cycle; eq = ({Anode,Cathode} in s2 == prev).
REQ-014 8-bit counter cnt: eq=0 -> cnt<=0; eq=1 and cnt<STABLE_CYC -> cnt<=cnt+1; saturates at STABLE_CYC.
REQ-015 Capture event SHALL occur on the edge where eq=1 and cnt==STABLE_CYC-1; exactly one capture per stable window, none while saturated.
REQ-016 Capture latency: outputs update on the (3+STABLE_CYC)th rising edge after the input change (7th for default).
REQ-017 Capture with Anode=4'b1111 (blanking) SHALL be ignored; no output changes.
REQ-018 Capture with two or more Anode bits low SHALL set anode_err; no other output changes.
REQ-019 Capture with exactly one Anode bit low SHALL decode ~Cathode (gfedcba, active-high) against: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-020 Match: selected nibble of data_out <= decoded value, corresponding digit_valid bit <= 1.
REQ-021 No match: seg_err <= 1, selected digit_valid bit <= 0, data_out nibble unchanged.
REQ-022 Re-capture of an already-valid digit SHALL overwrite its nibble; digit_valid unchanged.
REQ-023 When a capture leaves all four digit_valid bits set: on that same edge frame_out <= updated data_out value, frame_valid <= 1, digit_valid <= 4'b0000.
REQ-024 frame_valid SHALL be 0 on every edge without a frame completion; no back-to-back pulses possible (STABLE_CYC>=2).
REQ-025 data_out SHALL hold after frame completion; next frame overwrites nibble-by-nibble.
REQ-026 seg_err and anode_err SHALL clear only by reset.

Reset
REQ-027 reset=0: s1, s2, prev <= all ones (Anode=4'hF, Cathode=7'h7F); cnt <= 0.
REQ-028 reset=0: data_out, frame_out <= 16'h0000; digit_valid <= 4'h0; frame_valid, seg_err, anode_err <= 0.
REQ-029 Reset mid-frame SHALL discard partial digits; no frame_valid pulse during or on exit from reset.

Verification
REQ-030 Drive Anode=1110, Cathode=~7'h4F, hold 10 cycles -> on edge 7 data_out=16'h0003, digit_valid=0001; no further change.
REQ-031 Scan digits 0..3 with glyphs 3,A,b,F, 8 cycles each -> at digit-3 capture frame_out=16'hFbA3 (16'hFBA3), frame_valid one cycle high, digit_valid=0000.
REQ-032 Change Cathode every 3 cycles with STABLE_CYC=4 -> no capture, outputs unchanged.
REQ-033 Anode=1110, Cathode=~7'h00 held 8 cycles -> seg_err=1, digit_valid[0]=0, data_out unchanged; sticky through later good frames.
REQ-034 Anode=1100 held 8 cycles -> anode_err=1, data_out/digit_valid unchanged; Anode=1111 held -> no change.
REQ-035 Assert reset after digits 0..2 captured, release, send digit 3 only -> digit_valid=1000, no frame_valid, frame_out=0.
